// File: rtl/stream_deframer.sv
// ---------------------------------------------------------------------------
// stream_deframer
//
// This is the receive-side partner of the header/payload framer. It drains
// 32-bit words from a first-word-fall-through (FWFT) FIFO and checks each
// header word. For every good header it forwards exactly `length` payload
// words to a downstream FIFO.
//
// Header word layout:
//   [31:24] sync byte, which must equal SYNC_BYTE
//   [23:16] channel
//   [15:0]  payload length in words (0 .. MAX_LEN)
//
// Ports
//   clk        : the single system clock; all logic runs on its rising edge
//   rst        : synchronous, active-high reset
//   fifo_empty : source FWFT FIFO is empty
//   fifo_data  : source head word; valid whenever fifo_empty = 0
//   fifo_rd_en : pops the source head word (combinational)
//   pay_full   : downstream FIFO is full
//   pay_wr_en  : writes pay_data downstream (combinational)
//   pay_data   : payload word, a zero-latency pass-through of fifo_data
//   hdr_valid  : one-cycle pulse after a good header is accepted
//   hdr_chan   : channel field of the last accepted header
//   hdr_len    : length field of the last accepted header
//   pkt_done   : one-cycle pulse after the last payload word, or after a
//                zero-length header
//   err_sync   : one-cycle pulse after a header word with a bad sync byte
//   err_len    : one-cycle pulse after a header whose length exceeds MAX_LEN
//   pkt_count  : number of completed packets; wraps around
//   busy       : high while in the PAYLOAD state
// ---------------------------------------------------------------------------
module stream_deframer #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] MAX_LEN   = 16'd1024,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [31:0]      fifo_data,
  output logic             fifo_rd_en,
  input  logic             pay_full,
  output logic             pay_wr_en,
  output logic [31:0]      pay_data,
  output logic             hdr_valid,
  output logic [7:0]       hdr_chan,
  output logic [15:0]      hdr_len,
  output logic             pkt_done,
  output logic             err_sync,
  output logic             err_len,
  output logic [CNT_W-1:0] pkt_count,
  output logic             busy
);

  typedef enum logic [0:0] {
    HDR     = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t             state_reg,     state_next;
  logic [15:0]        remain_reg,    remain_next;
  logic [7:0]         hdr_chan_reg,  hdr_chan_next;
  logic [15:0]        hdr_len_reg,   hdr_len_next;
  logic [CNT_W-1:0]   pkt_count_reg, pkt_count_next;
  logic               hdr_valid_reg, hdr_valid_next;
  logic               pkt_done_reg,  pkt_done_next;
  logic               err_sync_reg,  err_sync_next;
  logic               err_len_reg,   err_len_next;

  // Header fields are decoded straight from the FWFT head word.
  logic [7:0]  word_sync;
  logic [7:0]  word_chan;
  logic [15:0] word_len;

  assign word_sync = fifo_data[31:24];
  assign word_chan = fifo_data[23:16];
  assign word_len  = fifo_data[15:0];

  // A payload word is moved only when the source holds data and the
  // downstream FIFO has room, so no word can be lost or duplicated.
  logic pay_xfer;
  assign pay_xfer = !fifo_empty && !pay_full;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HDR;
      remain_reg    <= 16'd0;
      hdr_chan_reg  <= 8'd0;
      hdr_len_reg   <= 16'd0;
      pkt_count_reg <= '0;
      hdr_valid_reg <= 1'b0;
      pkt_done_reg  <= 1'b0;
      err_sync_reg  <= 1'b0;
      err_len_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remain_reg    <= remain_next;
      hdr_chan_reg  <= hdr_chan_next;
      hdr_len_reg   <= hdr_len_next;
      pkt_count_reg <= pkt_count_next;
      hdr_valid_reg <= hdr_valid_next;
      pkt_done_reg  <= pkt_done_next;
      err_sync_reg  <= err_sync_next;
      err_len_reg   <= err_len_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and handshake logic
  // -------------------------------------------------------------------------
  always_comb begin
    // By default, hold all state, drop all pulses and do no transfer.
    state_next     = state_reg;
    remain_next    = remain_reg;
    hdr_chan_next  = hdr_chan_reg;
    hdr_len_next   = hdr_len_reg;
    pkt_count_next = pkt_count_reg;
    hdr_valid_next = 1'b0;
    pkt_done_next  = 1'b0;
    err_sync_next  = 1'b0;
    err_len_next   = 1'b0;
    fifo_rd_en     = 1'b0;
    pay_wr_en      = 1'b0;

    unique case (state_reg)
      HDR: begin
        // Header words are always consumed, good or bad. Because of this, a
        // bad sync byte makes the block resynchronise one word at a time.
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty) begin
          if (word_sync != SYNC_BYTE) begin
            err_sync_next = 1'b1;
          end else if (word_len > MAX_LEN) begin
            // Rejected headers leave the header registers untouched.
            err_len_next = 1'b1;
          end else begin
            hdr_chan_next  = word_chan;
            hdr_len_next   = word_len;
            hdr_valid_next = 1'b1;
            if (word_len == 16'd0) begin
              // An empty packet is complete as soon as its header is seen.
              pkt_done_next  = 1'b1;
              pkt_count_next = pkt_count_reg + 1'b1;
            end else begin
              remain_next = word_len;
              state_next  = PAYLOAD;
            end
          end
        end
      end

      PAYLOAD: begin
        // Payload words are never inspected. Words inside a payload that
        // look like headers are passed through unchanged.
        fifo_rd_en = pay_xfer;
        pay_wr_en  = pay_xfer;
        if (pay_xfer) begin
          remain_next = remain_reg - 16'd1;
          if (remain_reg == 16'd1) begin
            // Returning to HDR here means the next header can be popped in
            // the cycle right after the last payload word.
            pkt_done_next  = 1'b1;
            pkt_count_next = pkt_count_reg + 1'b1;
            state_next     = HDR;
          end
        end
      end

      default: begin
        state_next = HDR;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pay_data  = fifo_data;
  assign hdr_valid = hdr_valid_reg;
  assign hdr_chan  = hdr_chan_reg;
  assign hdr_len   = hdr_len_reg;
  assign pkt_done  = pkt_done_reg;
  assign err_sync  = err_sync_reg;
  assign err_len   = err_len_reg;
  assign pkt_count = pkt_count_reg;
  assign busy      = (state_reg == PAYLOAD);

endmodule

// File: tb/tb_stream_deframer.sv
// ---------------------------------------------------------------------------
// tb_stream_deframer
//
// Directed, table-driven bench for stream_deframer.
//
// Each table record describes one clock cycle:
//   - the inputs driven during that cycle;
//   - the combinational handshake outputs expected in that cycle;
//   - the registered outputs expected in that cycle, which reflect pops
//     made in earlier cycles.
//
// Hand-written sequences cover three multi-cycle corner cases:
//   - reset applied mid-packet;
//   - the pkt_count wrap;
//   - the reset state itself.
// ---------------------------------------------------------------------------
module tb_stream_deframer;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_rd_en;
  logic        pay_full;
  logic        pay_wr_en;
  logic [31:0] pay_data;
  logic        hdr_valid;
  logic [7:0]  hdr_chan;
  logic [15:0] hdr_len;
  logic        pkt_done;
  logic        err_sync;
  logic        err_len;
  logic [15:0] pkt_count;
  logic        busy;

  int n_checks;
  int n_fails;

  stream_deframer dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .pay_full   (pay_full),
    .pay_wr_en  (pay_wr_en),
    .pay_data   (pay_data),
    .hdr_valid  (hdr_valid),
    .hdr_chan   (hdr_chan),
    .hdr_len    (hdr_len),
    .pkt_done   (pkt_done),
    .err_sync   (err_sync),
    .err_len    (err_len),
    .pkt_count  (pkt_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        empty;
    logic        full;
    logic [31:0] data;
    logic        rd;
    logic        wr;
    logic        vld;
    logic        done;
    logic        es;
    logic        el;
    logic        bsy;
    logic [7:0]  chan;
    logic [15:0] len;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic        empty,
    input logic        full,
    input logic [31:0] data,
    input logic        rd,
    input logic        wr,
    input logic        vld,
    input logic        done,
    input logic        es,
    input logic        el,
    input logic        bsy,
    input logic [7:0]  chan,
    input logic [15:0] len,
    input logic [15:0] cnt
  );
    vec_t v;
    v.empty = empty;
    v.full  = full;
    v.data  = data;
    v.rd    = rd;
    v.wr    = wr;
    v.vld   = vld;
    v.done  = done;
    v.es    = es;
    v.el    = el;
    v.bsy   = bsy;
    v.chan  = chan;
    v.len   = len;
    v.cnt   = cnt;
    return v;
  endfunction

  // All DUT outputs except pay_data, packed into one vector:
  // {rd, wr, vld, done, es, el, busy, chan, len, cnt}
  function automatic logic [46:0] pack_exp(input vec_t v);
    return {v.rd, v.wr, v.vld, v.done, v.es, v.el, v.bsy,
            v.chan, v.len, v.cnt};
  endfunction

  function automatic logic [46:0] pack_act();
    return {fifo_rd_en, pay_wr_en, hdr_valid, pkt_done, err_sync, err_len,
            busy, hdr_chan, hdr_len, pkt_count};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Drive inputs just after the falling edge, then sample the outputs 1 ns
  // later, well before the next rising edge.
  task automatic drive(input logic empty, input logic full,
                       input logic [31:0] data);
    @(negedge clk);
    fifo_empty = empty;
    pay_full   = full;
    fifo_data  = data;
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst        = 1'b1;
    fifo_empty = 1'b1;
    pay_full   = 1'b0;
    fifo_data  = 32'd0;

    // Cycle vectors: empty, full, data | rd, wr, vld, done, es, el, busy,
    // chan, len, cnt
    // Packet: chan 3, len 4, no stalls.
    vecs.push_back(mk(0,0,32'hA5030004, 1,0,0,0,0,0,0, 8'd0,16'd0,16'd0));
    vecs.push_back(mk(0,0,32'd1,        1,1,1,0,0,0,1, 8'd3,16'd4,16'd0));
    vecs.push_back(mk(0,0,32'd2,        1,1,0,0,0,0,1, 8'd3,16'd4,16'd0));
    vecs.push_back(mk(0,0,32'd3,        1,1,0,0,0,0,1, 8'd3,16'd4,16'd0));
    vecs.push_back(mk(0,0,32'd4,        1,1,0,0,0,0,1, 8'd3,16'd4,16'd0));
    // The next header is popped the cycle after the last payload word.
    vecs.push_back(mk(0,0,32'hA5030004, 1,0,0,1,0,0,0, 8'd3,16'd4,16'd1));
    vecs.push_back(mk(0,0,32'd1,        1,1,1,0,0,0,1, 8'd3,16'd4,16'd1));
    vecs.push_back(mk(0,0,32'd2,        1,1,0,0,0,0,1, 8'd3,16'd4,16'd1));
    // pay_full is held high for 3 cycles after the 2nd payload word.
    vecs.push_back(mk(0,1,32'd3,        0,0,0,0,0,0,1, 8'd3,16'd4,16'd1));
    vecs.push_back(mk(0,1,32'd3,        0,0,0,0,0,0,1, 8'd3,16'd4,16'd1));
    vecs.push_back(mk(0,1,32'd3,        0,0,0,0,0,0,1, 8'd3,16'd4,16'd1));
    vecs.push_back(mk(0,0,32'd3,        1,1,0,0,0,0,1, 8'd3,16'd4,16'd1));
    vecs.push_back(mk(0,0,32'd4,        1,1,0,0,0,0,1, 8'd3,16'd4,16'd1));
    vecs.push_back(mk(1,0,32'd0,        0,0,0,1,0,0,0, 8'd3,16'd4,16'd2));
    // Two bad sync words, then a zero-length header on channel 7.
    vecs.push_back(mk(0,0,32'h12345678, 1,0,0,0,0,0,0, 8'd3,16'd4,16'd2));
    vecs.push_back(mk(0,0,32'h00000000, 1,0,0,0,1,0,0, 8'd3,16'd4,16'd2));
    vecs.push_back(mk(0,0,32'hA5070000, 1,0,0,0,1,0,0, 8'd3,16'd4,16'd2));
    vecs.push_back(mk(1,0,32'd0,        0,0,1,1,0,0,0, 8'd7,16'd0,16'd3));
    // len = 1025 is rejected; the next word is parsed as a header (len 2).
    vecs.push_back(mk(0,0,32'hA5010401, 1,0,0,0,0,0,0, 8'd7,16'd0,16'd3));
    vecs.push_back(mk(0,0,32'hA5020002, 1,0,0,0,0,1,0, 8'd7,16'd0,16'd3));
    // A payload word that looks like a header is passed through, and an
    // empty-FIFO stall inside the payload.
    vecs.push_back(mk(0,0,32'hA5FF0000, 1,1,1,0,0,0,1, 8'd2,16'd2,16'd3));
    vecs.push_back(mk(1,0,32'd0,        0,0,0,0,0,0,1, 8'd2,16'd2,16'd3));
    vecs.push_back(mk(0,0,32'h000000BB, 1,1,0,0,0,0,1, 8'd2,16'd2,16'd3));
    vecs.push_back(mk(1,0,32'd0,        0,0,0,1,0,0,0, 8'd2,16'd2,16'd4));

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_state", {17'd0, pack_act()}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].empty, vecs[i].full, vecs[i].data);
      check($sformatf("vec%0d_outputs", i), {17'd0, pack_act()},
            {17'd0, pack_exp(vecs[i])});
      if (vecs[i].wr)
        check($sformatf("vec%0d_pay_data", i), {32'd0, pay_data},
              {32'd0, vecs[i].data});
    end

    // Reset mid-packet: the header and 2 of 4 words are consumed, then
    // reset is applied.
    drive(0, 0, 32'hA5030004);
    drive(0, 0, 32'd1);
    drive(0, 0, 32'd2);
    @(negedge clk);
    fifo_empty = 1'b1;
    rst        = 1'b1;
    #1;
    check("rst_mid_no_done", {63'd0, pkt_done}, 64'd0);
    @(negedge clk);
    #1;
    check("rst_mid_outputs", {17'd0, pack_act()}, 64'd0);
    rst = 1'b0;
    // Leftover payload words 3 and 4 are now parsed as bad headers.
    drive(0, 0, 32'd3);
    check("rst_w3_pop", {62'd0, fifo_rd_en, pay_wr_en}, 64'd2);
    drive(0, 0, 32'd4);
    check("rst_w3_esync", {61'd0, err_sync, pay_wr_en, pkt_done}, 64'd4);
    drive(1, 0, 32'd0);
    check("rst_w4_esync", {61'd0, err_sync, pay_wr_en, pkt_done}, 64'd4);
    check("rst_cnt", {48'd0, pkt_count}, 64'd0);

    // Counter wrap: 65535 zero-length headers, then one more.
    @(negedge clk);
    fifo_empty = 1'b0;
    fifo_data  = 32'hA5000000;
    repeat (65535) @(posedge clk);
    drive(1, 0, 32'd0);
    check("cnt_preload", {48'd0, pkt_count}, 64'h0000_0000_0000_FFFF);
    drive(0, 0, 32'hA5000000);
    drive(1, 0, 32'd0);
    check("cnt_wrap", {45'd0, hdr_valid, pkt_done, busy, pkt_count},
          {45'd0, 1'b1, 1'b1, 1'b0, 16'd0});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
